// File: rtl/divider_pkg.sv
// ============================================================================
// divider_pkg : shared types and constants for the sequential divider
// Revision    : 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

  localparam int C_DIVIDEND_W = 8;
  localparam int C_DIVISOR_W  = 4;

  localparam logic [7:0] C_DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one restoring-division iteration (shift, compare, subtract)
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_W = C_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] i_prem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_prem,
  output logic                 o_qbit
);

  logic [DIVISOR_W:0]   w_shift;
  logic [DIVISOR_W-1:0] w_diff;
  logic                 w_ge;

  // The true difference is below the divisor, so the low bits alone are exact.
  always_comb begin
    w_shift = {i_prem, i_bit};
    w_ge    = (w_shift >= {1'b0, i_divisor});
    w_diff  = w_shift[DIVISOR_W-1:0] - i_divisor;
    o_prem  = w_ge ? w_diff : w_shift[DIVISOR_W-1:0];
    o_qbit  = w_ge;
  end

endmodule

`default_nettype wire

// File: rtl/divider_8x4_seq.sv
// ============================================================================
// divider_8x4_seq : unsigned restoring divider, one quotient bit per clock
// Revision        : 1.0
// ============================================================================
`default_nettype none

module divider_8x4_seq
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = C_DIVIDEND_W,
  parameter int DIVISOR_W  = C_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_prem;
  logic                  r_dbz;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_div_by_zero;
  logic [DIVISOR_W-1:0]  w_prem_next;
  logic                  w_qbit;
  logic                  w_busy;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_dvd[r_cnt]),
    .i_divisor (r_dvs),
    .o_prem    (w_prem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  // Working registers stay internal; the visible results change only on leaving DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_quo         <= '0;
      r_prem        <= '0;
      r_dbz         <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_cnt <= CNT_W'(DIVIDEND_W - 1);
            if (divisor == '0) begin
              r_quo  <= DIVIDEND_W'(C_DBZ_QUOTIENT);
              r_prem <= dividend[DIVISOR_W-1:0];
              r_dbz  <= 1'b1;
            end else begin
              r_quo  <= '0;
              r_prem <= '0;
              r_dbz  <= 1'b0;
            end
          end
        end
        CALC: begin
          r_prem <= w_prem_next;
          r_quo  <= {r_quo[DIVIDEND_W-2:0], w_qbit};
          r_cnt  <= r_cnt - 1'b1;
        end
        DONE: begin
          r_quotient    <= r_quo;
          r_remainder   <= r_prem;
          r_div_by_zero <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_divider_8x4_seq.sv
// ============================================================================
// tb_divider_8x4_seq : vector table, corner sequences and exhaustive sweep
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_divider_8x4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  always #5 clk = ~clk;

  divider_8x4_seq #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    exp_t       e;
    int         lat;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  exp_t last;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = a[3:0]; e.dbz = 1'b1;
    end else begin
      e.q = a / {4'd0, b}; e.r = 4'(a % {4'd0, b}); e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      check("done_single_cycle", int'(prev_done), 0);
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL spurious_done: got done=1, expected no pending request at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.dbz));
        last = e;
      end
    end
    prev_done = done;
  end

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input exp_t e,
                        input int lat, input int repulse_at);
    int n;
    int nbusy;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    n = 0;
    nbusy = 0;
    while (!done && n < 20) begin
      nbusy++;
      check("busy_high", int'(busy), 1);
      check("hold_quotient", int'(quotient), int'(last.q));
      check("hold_remainder", int'(remainder), int'(last.r));
      check("hold_dbz", int'(div_by_zero), int'(last.dbz));
      if (n == repulse_at) begin
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", n, lat);
    check("busy_cycles", nbusy, lat);
    check("busy_low_at_done", int'(busy), 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'd200, 4'd7,  '{8'd28,  4'd4, 1'b0}, 9};
    vecs[1] = '{8'd255, 4'd15, '{8'd17,  4'd0, 1'b0}, 9};
    vecs[2] = '{8'd5,   4'd9,  '{8'd0,   4'd5, 1'b0}, 9};
    vecs[3] = '{8'hA7,  4'd0,  '{8'hFF,  4'h7, 1'b1}, 1};
    vecs[4] = '{8'd0,   4'd1,  '{8'd0,   4'd0, 1'b0}, 9};
    vecs[5] = '{8'd255, 4'd1,  '{8'd255, 4'd0, 1'b0}, 9};
    vecs[6] = '{8'd15,  4'd15, '{8'd1,   4'd0, 1'b0}, 9};
    vecs[7] = '{8'd16,  4'd3,  '{8'd5,   4'd1, 1'b0}, 9};
    vecs[8] = '{8'd0,   4'd0,  '{8'hFF,  4'h0, 1'b1}, 1};

    last     = '{8'd0, 4'd0, 1'b0};
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);

    rst_n = 1'b1;
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat, -1);

    // A second start during CALC, then one during DONE, must both be dropped.
    run_op(8'd100, 4'd3, '{8'd33, 4'd1, 1'b0}, 9, 3);
    run_op(8'd100, 4'd3, '{8'd33, 4'd1, 1'b0}, 9, 8);
    repeat (12) @(negedge clk);
    check("idle_after_repulse", int'(busy), 0);

    // Abort an operation at iteration 5, then restart in the first cycle after release.
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    last = '{8'd0, 4'd0, 1'b0};
    repeat (3) begin
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_dbz", int'(div_by_zero), 0);
    end
    rst_n = 1'b1;
    run_op(8'd9, 4'd2, '{8'd4, 4'd1, 1'b0}, 9, -1);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), model(8'(a), 4'(b)), (b == 0) ? 1 : 9, -1);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
